// File: rtl/modbus_pkg.sv
// ---------------------------------------------------------------------------
// modbus_pkg
// Shared definitions for the Modbus RTU byte receiver:
//   - rx_fsm_t   : receiver FSM state encoding (3-bit)
//   - PAR_*      : parity mode encodings (none / odd / even)
//   - OVERSAMPLE : oversample ticks per bit
//   - TICK_*     : per-bit tick indices used for sampling and bit boundaries
//   - ERR_*      : bit positions inside rx_err
//   - majority3  : 2-of-3 vote used on the three mid-bit samples
// ---------------------------------------------------------------------------
package modbus_pkg;

    localparam int unsigned OVERSAMPLE = 16;

    localparam int unsigned PAR_NONE = 0;
    localparam int unsigned PAR_ODD  = 1;
    localparam int unsigned PAR_EVEN = 2;

    localparam int unsigned ERR_PARITY = 0;
    localparam int unsigned ERR_FRAME  = 1;

    localparam logic [3:0] TICK_SAMPLE_A = 4'd7;
    localparam logic [3:0] TICK_SAMPLE_B = 4'd8;
    localparam logic [3:0] TICK_DECIDE   = 4'd9;
    localparam logic [3:0] TICK_LAST     = 4'd15;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_fsm_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/modbus_uart_rx_os_tick_gen.sv
// ---------------------------------------------------------------------------
// os_tick_gen
// Oversample tick generator: divides clk_in by OS_DIV and counts ticks
// within a bit period (0..15, wraps naturally).
// Ports:
//   clk_in    in  system clock
//   rst_n_in  in  asynchronous active-low reset
//   clr       in  synchronous clear of divider and tick index (start detect)
//   tick      out one-cycle pulse every OS_DIV cycles
//   tick_idx  out index of the tick currently in progress within the bit
// ---------------------------------------------------------------------------
module os_tick_gen #(
    parameter int unsigned OS_DIV = 325
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       clr,
    output logic       tick,
    output logic [3:0] tick_idx
);

    localparam logic [15:0] CNT_MAX = 16'(OS_DIV - 1);

    logic [15:0] cnt_q;

    assign tick = (cnt_q == CNT_MAX) && !clr;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q    <= '0;
            tick_idx <= '0;
        end else if (clr) begin
            cnt_q    <= '0;
            tick_idx <= '0;
        end else if (tick) begin
            cnt_q    <= '0;
            tick_idx <= tick_idx + 4'd1;
        end else begin
            cnt_q    <= cnt_q + 16'd1;
        end
    end

endmodule

// File: rtl/modbus_uart_rx.sv
// ---------------------------------------------------------------------------
// modbus_uart_rx
// Byte-level UART receiver for the Modbus RTU slave. 16x oversampling,
// start-bit validation, 2-of-3 majority per bit, parity and stop checks.
// Ports:
//   clk_in    in  system clock
//   rst_n_in  in  asynchronous active-low reset
//   rx_pin    in  raw asynchronous line, idle high
//   rx_data   out last received byte (held until next rx_done)
//   rx_done   out one-cycle pulse per completed character
//   rx_err    out bit0 parity error, bit1 framing error (valid with rx_done)
//   rx_state  out high while a character is being received
// ---------------------------------------------------------------------------
module modbus_uart_rx
    import modbus_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 50000000,
    parameter int unsigned BAUD_RATE = 9600,
    parameter int unsigned PARITY    = PAR_EVEN
) (
    input  logic       clk_in,
    input  logic       rst_n_in,
    input  logic       rx_pin,
    output logic [7:0] rx_data,
    output logic       rx_done,
    output logic [1:0] rx_err,
    output logic       rx_state
);

    localparam int unsigned OS_DIV = (CLK_FREQ / BAUD_RATE) / OVERSAMPLE;

    rx_fsm_t     state_q, state_d;
    logic        sync_1_q, sync_2_q, line_prev_q;
    logic        fall, start_det;
    logic        tick;
    logic [3:0]  tick_idx;
    logic        decide, bit_end;
    logic        samp_a_q, samp_b_q;
    logic        bit_val;
    logic [7:0]  shift_q;
    logic [2:0]  bit_cnt_q;
    logic        par_err_q;
    logic        exp_par;
    logic        done_d;

    // Synchronizer plus one history flop for edge detection; all reset high
    // so a released reset on an idle line never looks like a start.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sync_1_q    <= 1'b1;
            sync_2_q    <= 1'b1;
            line_prev_q <= 1'b1;
        end else begin
            sync_1_q    <= rx_pin;
            sync_2_q    <= sync_1_q;
            line_prev_q <= sync_2_q;
        end
    end

    // Edge rather than level: a line held low after a framing error (break)
    // cannot restart reception until it has returned high.
    assign fall      = line_prev_q & ~sync_2_q;
    assign start_det = (state_q == ST_IDLE) && fall;

    os_tick_gen #(
        .OS_DIV (OS_DIV)
    ) u_tick_gen (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .clr      (start_det),
        .tick     (tick),
        .tick_idx (tick_idx)
    );

    assign decide  = tick && (tick_idx == TICK_DECIDE);
    assign bit_end = tick && (tick_idx == TICK_LAST);

    // The third vote is the live sample at the decision tick.
    assign bit_val = majority3(samp_a_q, samp_b_q, sync_2_q);
    assign exp_par = (^shift_q) ^ (PARITY == PAR_ODD);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (fall) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (decide && bit_val) begin
                    state_d = ST_IDLE;
                end else if (bit_end) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (bit_end && (bit_cnt_q == 3'd7)) begin
                    state_d = (PARITY == PAR_NONE) ? ST_STOP : ST_PARITY;
                end
            end
            ST_PARITY: begin
                if (bit_end) begin
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                // Finish at mid-stop so the silence timer starts early and a
                // back-to-back start edge is never missed.
                if (decide) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            samp_a_q  <= 1'b0;
            samp_b_q  <= 1'b0;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            par_err_q <= 1'b0;
            rx_data   <= '0;
            rx_err    <= '0;
            rx_done   <= 1'b0;
        end else begin
            rx_done <= done_d;

            if (tick && (tick_idx == TICK_SAMPLE_A)) begin
                samp_a_q <= sync_2_q;
            end
            if (tick && (tick_idx == TICK_SAMPLE_B)) begin
                samp_b_q <= sync_2_q;
            end

            if (start_det) begin
                bit_cnt_q <= '0;
                par_err_q <= 1'b0;
            end

            if (state_q == ST_DATA) begin
                if (decide) begin
                    shift_q <= {bit_val, shift_q[7:1]};
                end
                if (bit_end) begin
                    bit_cnt_q <= bit_cnt_q + 3'd1;
                end
            end

            if ((state_q == ST_PARITY) && decide) begin
                par_err_q <= (bit_val != exp_par);
            end

            if (done_d) begin
                rx_data            <= shift_q;
                rx_err[ERR_PARITY] <= par_err_q;
                rx_err[ERR_FRAME]  <= ~bit_val;
            end
        end
    end

    assign rx_state = (state_q != ST_IDLE);

endmodule
